pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
Parametrised, pipelined N-bit two-operand adder with carry-in, selectable signed/unsigned overflow and a valid-tagged datapath. The carry chain is cut into STAGES equal slices with a register between slices, so one new operand pair is accepted every cycle. It replaces fixed-width ripple adders where wide operands would break timing, and feeds accumulator and ALU datapaths.

Parameters:
WIDTH, 16, operand/sum width in bits; must be >= 2.
STAGES, 4, number of pipeline slices; must divide WIDTH exactly; 1 is legal.

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; kills all in-flight valid tags
in_valid  input  1  operand pair presented this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry into bit 0
is_signed  input  1  1 = two's-complement overflow rule, 0 = unsigned rule
out_valid  output  1  sum/overflow valid this cycle
sum  output  WIDTH  result
overflow  output  1  overflow flag for this result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (n_rst).
- Reset (n_rst=0): all pipeline registers cleared; out_valid=0, sum=0, overflow=0 immediately, held until release.
- SLICE = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of a and b plus the carry registered out of stage k-1 (stage 0 uses carry_in).
- Operand skew: upper slices of a/b are delayed k cycles so they meet their carry; lower-slice sum bits are delayed so all bits of a result leave together.
- Latency: exactly STAGES cycles from in_valid sample to out_valid. Throughput 1 per cycle, no backpressure; a result is presented for one cycle only.
- Valid tag and is_signed travel with the data; non-valid bubbles propagate, and sum/overflow hold their last valid values while out_valid=0.
- Overflow: unsigned = carry out of bit WIDTH-1; signed = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Sum is modulo 2^WIDTH (wraps) unless the optional feature is enabled.
- clear=1: all valid tags forced to 0 on the next edge; data regs may keep values; out_valid=0 the cycle after. clear and in_valid together: the new operand is also dropped.
- Reset mid-operation: all in-flight operations are discarded; nothing is emitted after release until a new in_valid has traversed STAGES cycles.
- STAGES=1: single registered full adder, latency 1.

Optional Feature:
ADDER_SATURATE_EN
- Defined: when overflow=1 the sum is clamped. Unsigned: all ones. Signed: 0111..1 if operand a MSB=0, 1000..0 if a MSB=1. overflow is still reported. Clamp applied in the final stage; latency unchanged.
- Not defined: sum wraps; no clamp logic synthesised.

Decomposition:
- Package adder_pkg: stage register struct (valid, is_signed, carry, partial sum) as a parameterised-width typedef via localparam-sized fields; overflow-mode enum (OVF_UNSIGNED, OVF_SIGNED).
- Sub-module adder_slice: combinational SLICE-bit ripple adder (a, b, carry_in -> sum, carry_out, carry_msb_in for the signed rule); instantiated STAGES times with generate.

Test Plan:
- WIDTH=16, STAGES=4, unsigned: a=0xFFFF, b=0x0001, cin=0 -> 4 cycles later out_valid=1, sum=0x0000, overflow=1.
- Signed: a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1; a=0xFFFF, b=0x0001 signed -> sum=0x0000, overflow=0.
- Streaming: 20 back-to-back random pairs with mixed is_signed -> 20 consecutive out_valid cycles, each matches reference model in order; a bubble in input gives exactly one out_valid=0 gap.
- clear asserted 2 cycles after three valid inputs -> no out_valid for those; input issued after clear emerges normally at 4-cycle latency.
- n_rst pulsed low mid-stream -> outputs 0 asynchronously; no stale results after release.
- ADDER_SATURATE_EN: 0x7FFF+0x0001 signed -> 0x7FFF, overflow=1; 0x8000+0xFFFF signed -> 0x8000, overflow=1; 0xFFFF+0x0002 unsigned -> 0xFFFF, overflow=1.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and helpers for pipelined_adder.
// Contents: ovf_mode_e (overflow rule), stage_ctrl_t (per-stage control tag),
//           ovf_bit() (selects the overflow rule from the MSB carries).
package adder_pkg;

   typedef enum logic {
      OVF_UNSIGNED = 1'b0,
      OVF_SIGNED   = 1'b1
   } ovf_mode_e;

   // Control fields carried alongside each stage's partial sum
   typedef struct packed {
      logic      valid;
      ovf_mode_e mode;
      logic      carry;
   } stage_ctrl_t;

   function automatic logic ovf_bit(ovf_mode_e mode, logic c_msb_in, logic c_out);
      return (mode == OVF_SIGNED) ? (c_msb_in ^ c_out) : c_out;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SLICE-bit adder used for one stage of the carry chain.
// Ports: a, b (slice operands), carry_in -> sum, carry_out (out of MSB),
//        carry_msb_in (carry into MSB, needed for the signed overflow rule).
module adder_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             carry_in,
   output logic [SLICE-1:0] sum,
   output logic             carry_out,
   output logic             carry_msb_in
);

   assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, carry_in};
   // The MSB sum bit is a^b^cin at that position, so the carry into it falls out directly
   assign carry_msb_in = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder whose carry chain is cut into STAGES registered slices.
// Ports: clk, n_rst (async active-low reset), clear (sync flush of all valid tags),
//        in_valid, a, b, carry_in, is_signed (operand side, one pair per cycle),
//        out_valid, sum, overflow (result side, STAGES cycles after in_valid).
// Build option: define ADDER_SATURATE_EN to clamp sum on overflow in the final stage.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             is_signed,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);

   localparam int SLICE = WIDTH / STAGES;

   typedef struct packed {
      stage_ctrl_t      ctl;
      logic [WIDTH-1:0] psum;
   } stage_t;

   // Registered outputs of each stage; a_r/b_r hold the not-yet-added operand
   // bits shifted down so the next slice always reads the bottom SLICE bits.
   // psum fills from the top, so after the last stage it is the aligned sum.
   stage_t           st_r [STAGES];
   logic [WIDTH-1:0] a_r  [STAGES];
   logic [WIDTH-1:0] b_r  [STAGES];
   logic             ovf_r;

   logic [WIDTH-1:0] a_i  [STAGES];
   logic [WIDTH-1:0] b_i  [STAGES];
   logic [WIDTH-1:0] lo_i [STAGES];
   logic [WIDTH-1:0] ps_n [STAGES];
   logic             c_i  [STAGES];
   logic             v_i  [STAGES];
   ovf_mode_e        m_i  [STAGES];
   logic [SLICE-1:0] s    [STAGES];
   logic             co   [STAGES];
   logic             cm   [STAGES];
   logic             ovf_n;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] acc;
      if (k == 0) begin : g_src
         assign a_i[k]  = a;
         assign b_i[k]  = b;
         assign c_i[k]  = carry_in;
         assign v_i[k]  = in_valid;
         assign m_i[k]  = is_signed ? OVF_SIGNED : OVF_UNSIGNED;
         assign lo_i[k] = '0;
      end else begin : g_src
         assign a_i[k]  = a_r[k-1];
         assign b_i[k]  = b_r[k-1];
         assign c_i[k]  = st_r[k-1].ctl.carry;
         assign v_i[k]  = st_r[k-1].ctl.valid;
         assign m_i[k]  = st_r[k-1].ctl.mode;
         assign lo_i[k] = st_r[k-1].psum;
      end
      adder_slice #(.SLICE(SLICE)) u_slice (
         .a           (a_i[k][SLICE-1:0]),
         .b           (b_i[k][SLICE-1:0]),
         .carry_in    (c_i[k]),
         .sum         (s[k]),
         .carry_out   (co[k]),
         .carry_msb_in(cm[k])
      );
      assign acc = (lo_i[k] >> SLICE) | (WIDTH'(s[k]) << (WIDTH - SLICE));
      if (k == STAGES - 1) begin : g_last
         assign ovf_n = ovf_bit(m_i[k], cm[k], co[k]);
`ifdef ADDER_SATURATE_EN
         // Signed overflow direction follows a's sign: both operands share it when overflow occurs
         assign ps_n[k] = !ovf_n ? acc :
                          (m_i[k] == OVF_UNSIGNED) ? '1 :
                          {a_i[k][SLICE-1], {(WIDTH-1){~a_i[k][SLICE-1]}}};
`else
         assign ps_n[k] = acc;
`endif
      end else begin : g_mid
         assign ps_n[k] = acc;
      end
   end

   // Data only moves with a live tag, so the output holds its last valid result
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            st_r[k] <= '0;
            a_r[k]  <= '0;
            b_r[k]  <= '0;
         end
         ovf_r <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            st_r[k].ctl.valid <= v_i[k] && !clear;
            if (v_i[k] && !clear) begin
               st_r[k].ctl.mode  <= m_i[k];
               st_r[k].ctl.carry <= co[k];
               st_r[k].psum      <= ps_n[k];
               a_r[k]            <= a_i[k] >> SLICE;
               b_r[k]            <= b_i[k] >> SLICE;
            end
         end
         if (v_i[STAGES-1] && !clear) ovf_r <= ovf_n;
      end
   end

   assign out_valid = st_r[STAGES-1].ctl.valid;
   assign sum       = st_r[STAGES-1].psum;
   assign overflow  = ovf_r;

endmodule
